// File: rtl/int_sequencer_pkg.sv
// Shared definitions for the interrupt sequencer: int_type codes, vector addresses,
// sequence-cycle limits and FSM state type.
package int_sequencer_pkg;

  typedef enum logic [1:0] {
    IntBrk = 2'b00,
    IntIrq = 2'b01,
    IntNmi = 2'b10,
    IntRst = 2'b11
  } int_type_e;

  typedef enum logic {
    StIdle,
    StSeq
  } seq_state_e;

  localparam logic [15:0] VecNmi    = 16'hFFFA;
  localparam logic [15:0] VecRst    = 16'hFFFC;
  localparam logic [15:0] VecIrqBrk = 16'hFFFE;

  localparam logic [2:0] SeqCycFirst = 3'd1;
  localparam logic [2:0] SeqCycLast  = 3'd7;
  localparam logic [2:0] WrInhFirst  = 3'd3;
  localparam logic [2:0] WrInhLast   = 3'd5;
  localparam logic [2:0] SetICyc     = 3'd6;
  localparam logic [2:0] HijackLast  = 3'd5;

  function automatic logic [15:0] vec_for(int_type_e t);
    logic [15:0] v;
    case (t)
      IntNmi:  v = VecNmi;
      IntRst:  v = VecRst;
      default: v = VecIrqBrk;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/int_sequencer_nmi_edge_det.sv
// NMI rising-edge detector with sticky pending flag; req_o includes an edge seen this
// cycle so a request and its consumption can happen in the same cycle.
module int_sequencer_nmi_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic nmi_i,
  input  logic clr_i,
  output logic req_o
);

  logic nmi_prev_q;
  logic pend_q, pend_d;
  logic edge_now;

  assign edge_now = en_i & nmi_i & ~nmi_prev_q;
  assign req_o    = pend_q | edge_now;

  always_comb begin
    pend_d = pend_q;
    if (en_i) begin
      pend_d = req_o & ~clr_i;
    end
  end

  // Sampling nmi during reset stops a level held across reset from looking like an edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      nmi_prev_q <= nmi_i;
      pend_q     <= 1'b0;
    end else if (en_i) begin
      nmi_prev_q <= nmi_i;
      pend_q     <= pend_d;
    end
  end

endmodule

// File: rtl/int_sequencer.sv
// Interrupt sequencer: selects RST/NMI/IRQ/BRK at instruction boundaries and steps a
// 7-cycle push/vector sequence. Define INT_NMI_HIJACK_EN to let NMI hijack IRQ/BRK.
module int_sequencer
  import int_sequencer_pkg::*;
(
  input  logic        phi1,
  input  logic        rst,
  input  logic        rdy,
  input  logic        nmi,
  input  logic        irq,
  input  logic        t1_now,
  input  logic [7:0]  opcode,
  input  logic        i_flag,
  output logic        force_brk,
  output logic [1:0]  int_type,
  output logic [15:0] vec_addr,
  output logic        b_flag,
  output logic        wr_inhibit,
  output logic        set_i,
  output logic        busy,
  output logic [2:0]  seq_cyc
);

  seq_state_e state_q, state_d;
  logic [2:0] seq_cyc_q, seq_cyc_d;
  int_type_e  int_type_q, int_type_d;
  logic       b_flag_q, b_flag_d;
  logic       rst_pend_q, rst_pend_d;

  logic nmi_req, nmi_clr;
  logic irq_req, brk_req, boundary, hw_sel, any_sel;

  int_sequencer_nmi_edge_det nmi_edge_det (
    .clk_i (phi1),
    .rst_i (rst),
    .en_i  (rdy),
    .nmi_i (nmi),
    .clr_i (nmi_clr),
    .req_o (nmi_req)
  );

  assign irq_req  = irq & ~i_flag;
  assign brk_req  = (opcode == 8'h00);
  assign boundary = (state_q == StIdle) & t1_now & rdy;
  assign hw_sel   = boundary & (rst_pend_q | nmi_req | irq_req);
  assign any_sel  = hw_sel | (boundary & brk_req);

`ifdef INT_NMI_HIJACK_EN
  logic hijack;
  assign hijack = (state_q == StSeq) && (seq_cyc_q <= HijackLast) && nmi_req &&
                  ((int_type_q == IntIrq) || (int_type_q == IntBrk));
`endif

  always_ff @(posedge phi1) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (any_sel) state_d = StSeq;
      StSeq:   if (rdy && (seq_cyc_q == SeqCycLast)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    seq_cyc_d  = seq_cyc_q;
    int_type_d = int_type_q;
    b_flag_d   = b_flag_q;
    rst_pend_d = rst_pend_q;
    nmi_clr    = 1'b0;
    if (any_sel) begin
      seq_cyc_d = SeqCycFirst;
      if (rst_pend_q) begin
        int_type_d = IntRst;
        rst_pend_d = 1'b0;
      end else if (nmi_req) begin
        int_type_d = IntNmi;
        nmi_clr    = 1'b1;
      end else if (irq_req) begin
        int_type_d = IntIrq;
      end else begin
        int_type_d = IntBrk;
      end
      b_flag_d = (int_type_d == IntBrk);
    end else if ((state_q == StSeq) && rdy) begin
      seq_cyc_d = (seq_cyc_q == SeqCycLast) ? 3'd0 : seq_cyc_q + 3'd1;
`ifdef INT_NMI_HIJACK_EN
      // b_flag stays as captured so a hijacked BRK still pushes B=1.
      if (hijack) begin
        int_type_d = IntNmi;
        nmi_clr    = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge phi1) begin
    if (rst) begin
      seq_cyc_q  <= 3'd0;
      int_type_q <= IntRst;
      b_flag_q   <= 1'b0;
      rst_pend_q <= 1'b1;
    end else begin
      seq_cyc_q  <= seq_cyc_d;
      int_type_q <= int_type_d;
      b_flag_q   <= b_flag_d;
      rst_pend_q <= rst_pend_d;
    end
  end

  always_comb begin
    force_brk  = hw_sel & ~rst;
    int_type   = int_type_q;
    vec_addr   = vec_for(int_type_q);
    b_flag     = b_flag_q;
    wr_inhibit = (int_type_q == IntRst) && (seq_cyc_q >= WrInhFirst) &&
                 (seq_cyc_q <= WrInhLast);
    set_i      = (seq_cyc_q == SetICyc);
    busy       = (seq_cyc_q != 3'd0);
    seq_cyc    = seq_cyc_q;
  end

endmodule

// File: tb/tb_int_sequencer.sv
// Scoreboard bench for int_sequencer: a per-cycle reference model pushes expected outputs,
// a monitor pops and compares at the falling edge. Honours INT_NMI_HIJACK_EN.
module tb_int_sequencer;

  logic        phi1 = 1'b0;
  logic        rst = 1'b1, rdy = 1'b1, nmi = 1'b0, irq = 1'b0, t1_now = 1'b0, i_flag = 1'b1;
  logic [7:0]  opcode = 8'hEA;
  logic        force_brk, b_flag, wr_inhibit, set_i, busy;
  logic [1:0]  int_type;
  logic [15:0] vec_addr;
  logic [2:0]  seq_cyc;

  int_sequencer dut (
    .phi1       (phi1),
    .rst        (rst),
    .rdy        (rdy),
    .nmi        (nmi),
    .irq        (irq),
    .t1_now     (t1_now),
    .opcode     (opcode),
    .i_flag     (i_flag),
    .force_brk  (force_brk),
    .int_type   (int_type),
    .vec_addr   (vec_addr),
    .b_flag     (b_flag),
    .wr_inhibit (wr_inhibit),
    .set_i      (set_i),
    .busy       (busy),
    .seq_cyc    (seq_cyc)
  );

  always #5 phi1 = ~phi1;

`ifdef INT_NMI_HIJACK_EN
  localparam bit Hijack = 1'b1;
`else
  localparam bit Hijack = 1'b0;
`endif

  typedef struct {
    logic [2:0]  cyc;
    logic [1:0]  typ;
    logic [15:0] vec;
    logic        b, wr, si, bz, fb;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Stimulus shadows, applied to the DUT 2 time units after each rising edge.
  logic       s_rst = 1'b1, s_rdy = 1'b1, s_nmi = 1'b0, s_irq = 1'b0, s_t1 = 1'b0;
  logic       s_i = 1'b1;
  logic [7:0] s_op = 8'hEA;

  // Reference model state: what the sequencer holds after the most recent rising edge.
  bit m_known = 0;
  int m_cyc = 0;
  int m_type = 3;
  bit m_b = 0, m_rpend = 0, m_npend = 0, m_nprev = 0;

  function automatic logic [15:0] vec_of(input int t);
    if (t == 2) return 16'hFFFA;
    if (t == 3) return 16'hFFFC;
    return 16'hFFFE;
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, want %h", name, $time, got, want);
    end
  endtask

  task automatic step();
    exp_t e;
    bit   edge_n, nreq, sel;
    @(posedge phi1);
    #2;
    rst = s_rst; rdy = s_rdy; nmi = s_nmi; irq = s_irq;
    t1_now = s_t1; opcode = s_op; i_flag = s_i;
    edge_n = s_rdy && s_nmi && !m_nprev;
    nreq   = m_npend || edge_n;
    if (m_known) begin
      e.cyc = 3'(m_cyc);
      e.typ = 2'(m_type);
      e.vec = vec_of(m_type);
      e.b   = m_b;
      e.bz  = (m_cyc != 0);
      e.si  = (m_cyc == 6);
      e.wr  = (m_type == 3) && (m_cyc >= 3) && (m_cyc <= 5);
      e.fb  = !s_rst && s_rdy && s_t1 && (m_cyc == 0) && (m_rpend || nreq || (s_irq && !s_i));
      exp_q.push_back(e);
    end
    if (s_rst) begin
      m_known = 1; m_cyc = 0; m_type = 3; m_b = 0;
      m_rpend = 1; m_npend = 0; m_nprev = s_nmi;
    end else if (m_known && s_rdy) begin
      m_nprev = s_nmi;
      m_npend = nreq;
      if (m_cyc == 0) begin
        if (s_t1) begin
          sel = 1;
          if (m_rpend) begin m_type = 3; m_rpend = 0; end
          else if (m_npend) begin m_type = 2; m_npend = 0; end
          else if (s_irq && !s_i) m_type = 1;
          else if (s_op == 8'h00) m_type = 0;
          else sel = 0;
          if (sel) begin
            m_cyc = 1;
            m_b   = (m_type == 0);
          end
        end
      end else begin
        if (Hijack && m_cyc <= 5 && m_type <= 1 && m_npend) begin
          m_type  = 2;
          m_npend = 0;
        end
        m_cyc = (m_cyc + 1) % 8;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge phi1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("seq_cyc",    {13'd0, seq_cyc},    {13'd0, e.cyc});
        check("int_type",   {14'd0, int_type},   {14'd0, e.typ});
        check("vec_addr",   vec_addr,            e.vec);
        check("b_flag",     {15'd0, b_flag},     {15'd0, e.b});
        check("wr_inhibit", {15'd0, wr_inhibit}, {15'd0, e.wr});
        check("set_i",      {15'd0, set_i},      {15'd0, e.si});
        check("busy",       {15'd0, busy},       {15'd0, e.bz});
        check("force_brk",  {15'd0, force_brk},  {15'd0, e.fb});
      end
    end
  end

  initial begin : driver
    // Reset, then the post-reset RST sequence.
    idle(3);
    s_rst = 0; idle(1);
    s_t1 = 1; idle(1); s_t1 = 0; idle(9);
    // Unmasked IRQ, then masked IRQ gives no sequence.
    s_irq = 1; s_i = 0; s_t1 = 1; idle(1); s_t1 = 0; idle(9); s_irq = 0;
    s_irq = 1; s_i = 1; s_t1 = 1; idle(1); s_t1 = 0; idle(3); s_irq = 0;
    // BRK opcode with nothing pending.
    s_op = 8'h00; s_t1 = 1; idle(1); s_t1 = 0; s_op = 8'hEA; idle(9);
    // NMI and IRQ rise together: NMI first, IRQ at the following boundary.
    s_nmi = 1; s_irq = 1; s_i = 0; s_t1 = 1; idle(1); s_t1 = 0; idle(8);
    s_t1 = 1; idle(1); s_t1 = 0; idle(9); s_irq = 0; s_nmi = 0; idle(1);
    // NMI rising during seq_cyc 4 of an IRQ sequence.
    s_irq = 1; s_t1 = 1; idle(1); s_t1 = 0; s_irq = 0; idle(3);
    s_nmi = 1; idle(6); s_nmi = 0;
    s_t1 = 1; idle(1); s_t1 = 0; idle(9);
    // rdy stall at seq_cyc 2.
    s_irq = 1; s_t1 = 1; idle(1); s_t1 = 0; s_irq = 0; idle(1);
    s_rdy = 0; idle(3); s_rdy = 1; idle(7);
    // NMI held high with boundaries every cycle: exactly one NMI.
    s_nmi = 1; s_t1 = 1; idle(20); s_nmi = 0; s_t1 = 0; idle(3);
    // Reset in the middle of a sequence.
    s_irq = 1; s_t1 = 1; idle(1); s_t1 = 0; idle(3);
    s_rst = 1; idle(2); s_rst = 0; s_irq = 0; idle(2);
    s_t1 = 1; idle(1); s_t1 = 0; idle(9);
    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      s_rst = ($urandom_range(0, 199) == 0);
      s_rdy = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 29) == 0) s_nmi = ~s_nmi;
      if ($urandom_range(0, 9) == 0) s_irq = ~s_irq;
      if ($urandom_range(0, 14) == 0) s_i = ~s_i;
      s_t1 = ($urandom_range(0, 2) == 0);
      s_op = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      step();
    end
    @(negedge phi1);
    @(posedge phi1);
    check("queue_drain", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
